// File: rtl/processor_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the accumulator datapath / PC / memory.
// The FSM side is the master; the datapath side is the slave.
interface processor_control_fsm_if;
  logic [3:0] opcode;
  logic       isZero;

  logic       IR_Write;
  logic       Asel;
  logic       Bsel;
  logic       Awrite;
  logic       Bwrite;
  logic [2:0] ALUcontrol;
  logic       ItypeSel;
  logic       ALUOutWrite;
  logic       iszero_write;
  logic       reg_write;
  logic       RegDst;
  logic [3:0] write_address;
  logic       MemtoReg;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  opcode, isZero,
    output IR_Write, Asel, Bsel, Awrite, Bwrite, ALUcontrol, ItypeSel, ALUOutWrite,
           iszero_write, reg_write, RegDst, write_address, MemtoReg, MemRead, MemWrite,
           IorD, PCWrite, PCSource, halted, state
  );

  modport slave (
    output opcode, isZero,
    input  IR_Write, Asel, Bsel, Awrite, Bwrite, ALUcontrol, ItypeSel, ALUOutWrite,
           iszero_write, reg_write, RegDst, write_address, MemtoReg, MemRead, MemWrite,
           IorD, PCWrite, PCSource, halted, state
  );
endinterface

// File: rtl/processor_control_fsm.sv
// Multicycle control unit for the accumulator datapath: fetch, decode and sequence
// every datapath, PC and memory strobe. Moore outputs except PCWrite in S_BRANCH.
module processor_control_fsm #(
  parameter logic [3:0] ACC_ADDR = 4'hF
) (
  input logic                    Clock,
  input logic                    Reset,
  processor_control_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    S_RESET    = 4'h0,
    S_FETCH    = 4'h1,
    S_DECODE   = 4'h2,
    S_EXEC_R   = 4'h3,
    S_EXEC_I   = 4'h4,
    S_ALU_WB   = 4'h5,
    S_MEM_ADDR = 4'h6,
    S_MEM_RD   = 4'h7,
    S_MEM_WB   = 4'h8,
    S_MEM_WR   = 4'h9,
    S_BRANCH   = 4'hA,
    S_JUMP     = 4'hB,
    S_HALT     = 4'hC
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       asel;
    logic       bsel;
    logic       awrite;
    logic       bwrite;
    logic [2:0] alu_control;
    logic       itype_sel;
    logic       aluout_write;
    logic       iszero_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  state_t state_q;
  ctrl_t  ctrl_q;

  function automatic state_t next_state(state_t s, logic [3:0] op);
    case (s)
      S_RESET:    return S_FETCH;
      S_FETCH:    return S_DECODE;
      S_DECODE: begin
        if (op inside {[4'h0:4'h6]}) return S_EXEC_R;
        else if (op == 4'h7)         return S_EXEC_I;
        else if (op inside {4'h8, 4'h9}) return S_MEM_ADDR;
        else if (op == 4'hA)         return S_BRANCH;
        else if (op == 4'hB)         return S_JUMP;
        else if (op == 4'hF)         return S_HALT;
        else                         return S_FETCH;
      end
      S_EXEC_R:   return S_ALU_WB;
      S_EXEC_I:   return S_ALU_WB;
      S_ALU_WB:   return S_FETCH;
      S_MEM_ADDR: return (op == 4'h9) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   return S_MEM_WB;
      S_MEM_WB:   return S_FETCH;
      S_MEM_WR:   return S_FETCH;
      S_BRANCH:   return S_FETCH;
      S_JUMP:     return S_FETCH;
      S_HALT:     return S_HALT;
      // Unused encodings recover through S_RESET.
      default:    return S_RESET;
    endcase
  endfunction

  function automatic ctrl_t moore_ctrl(state_t s, logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      S_DECODE: begin
        c.asel   = 1'b1;
        c.awrite = 1'b1;
        c.bwrite = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_control  = 3'(op + 4'd1);
        c.aluout_write = 1'b1;
        c.iszero_write = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_control  = 3'd1;
        c.itype_sel    = 1'b1;
        c.aluout_write = 1'b1;
        c.iszero_write = 1'b1;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_MEM_ADDR: c.aluout_write = 1'b1;
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: c.pc_source = 2'b01;
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only; outputs are decoded from the
  // state being entered so they are registered and line up with that state's cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= next_state(state_q, ctrl.opcode);
      ctrl_q  <= moore_ctrl(next_state(state_q, ctrl.opcode), ctrl.opcode);
    end
  end

  assign ctrl.IR_Write      = ctrl_q.ir_write;
  assign ctrl.Asel          = ctrl_q.asel;
  assign ctrl.Bsel          = ctrl_q.bsel;
  assign ctrl.Awrite        = ctrl_q.awrite;
  assign ctrl.Bwrite        = ctrl_q.bwrite;
  assign ctrl.ALUcontrol    = ctrl_q.alu_control;
  assign ctrl.ItypeSel      = ctrl_q.itype_sel;
  assign ctrl.ALUOutWrite   = ctrl_q.aluout_write;
  assign ctrl.iszero_write  = ctrl_q.iszero_write;
  assign ctrl.reg_write     = ctrl_q.reg_write;
  assign ctrl.RegDst        = ctrl_q.reg_dst;
  assign ctrl.write_address = ctrl_q.reg_dst ? ACC_ADDR : 4'h0;
  assign ctrl.MemtoReg      = ctrl_q.mem_to_reg;
  assign ctrl.MemRead       = ctrl_q.mem_read;
  assign ctrl.MemWrite      = ctrl_q.mem_write;
  assign ctrl.IorD          = ctrl_q.iord;
  assign ctrl.PCSource      = ctrl_q.pc_source;
  assign ctrl.halted        = ctrl_q.halted;
  assign ctrl.state         = state_q;

  // The conditional branch takes the live zero flag so BEQZ completes in one cycle.
  assign ctrl.PCWrite = ctrl_q.pc_write | ((state_q == S_BRANCH) & ctrl.isZero);

endmodule

// File: tb/tb_processor_control_fsm.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle control
// vectors; a monitor pops and compares one vector per clock.
module tb_processor_control_fsm;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  processor_control_fsm_if bus ();

  processor_control_fsm #(.ACC_ADDR(4'hF)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .ctrl  (bus)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       ir_write;
    logic       asel;
    logic       bsel;
    logic       awrite;
    logic       bwrite;
    logic [2:0] alu;
    logic       itype;
    logic       aluout;
    logic       zwr;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       halted;
    logic [3:0] waddr;
  } vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  vec_t  plan[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t observe();
    vec_t r;
    r.state      = bus.state;
    r.ir_write   = bus.IR_Write;
    r.asel       = bus.Asel;
    r.bsel       = bus.Bsel;
    r.awrite     = bus.Awrite;
    r.bwrite     = bus.Bwrite;
    r.alu        = bus.ALUcontrol;
    r.itype      = bus.ItypeSel;
    r.aluout     = bus.ALUOutWrite;
    r.zwr        = bus.iszero_write;
    r.reg_write  = bus.reg_write;
    r.reg_dst    = bus.RegDst;
    r.mem_to_reg = bus.MemtoReg;
    r.mem_read   = bus.MemRead;
    r.mem_write  = bus.MemWrite;
    r.iord       = bus.IorD;
    r.pc_write   = bus.PCWrite;
    r.pc_source  = bus.PCSource;
    r.halted     = bus.halted;
    r.waddr      = bus.write_address;
    return r;
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t  e;
    string n;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, observe(), e);
      end
    end
  end

  function automatic vec_t in_state(logic [3:0] st);
    vec_t r;
    r = '0;
    r.state = st;
    return r;
  endfunction

  // Reference: what each instruction class asks of the datapath, cycle by cycle.
  task automatic build_plan(input logic [3:0] op, input logic iz);
    vec_t r;
    plan.delete();
    r = in_state(4'd1); r.mem_read = 1; r.ir_write = 1; r.pc_write = 1; plan.push_back(r);
    r = in_state(4'd2); r.asel = 1; r.awrite = 1; r.bwrite = 1;         plan.push_back(r);
    if (op <= 4'h7) begin
      if (op == 4'h7) begin
        r = in_state(4'd4); r.alu = 3'd1; r.itype = 1;
      end else begin
        r = in_state(4'd3); r.alu = 3'(op + 4'd1);
      end
      r.aluout = 1; r.zwr = 1; plan.push_back(r);
      r = in_state(4'd5); r.reg_write = 1; r.reg_dst = 1; r.waddr = 4'hF; plan.push_back(r);
    end else if (op == 4'h8 || op == 4'h9) begin
      r = in_state(4'd6); r.aluout = 1; plan.push_back(r);
      if (op == 4'h8) begin
        r = in_state(4'd7); r.mem_read = 1; r.iord = 1; plan.push_back(r);
        r = in_state(4'd8); r.reg_write = 1; r.reg_dst = 1; r.mem_to_reg = 1; r.waddr = 4'hF;
        plan.push_back(r);
      end else begin
        r = in_state(4'd9); r.mem_write = 1; r.iord = 1; plan.push_back(r);
      end
    end else if (op == 4'hA) begin
      r = in_state(4'd10); r.pc_source = 2'b01; r.pc_write = iz; plan.push_back(r);
    end else if (op == 4'hB) begin
      r = in_state(4'd11); r.pc_source = 2'b10; r.pc_write = 1; plan.push_back(r);
    end else if (op == 4'hF) begin
      r = in_state(4'd12); r.halted = 1;
      for (int k = 0; k < 11; k++) plan.push_back(r);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] op, input logic iz,
                       input vec_t e, input string n);
    @(posedge Clock);
    #1;
    Reset       = rst;
    bus.opcode  = op;
    bus.isZero  = iz;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // abort >= 0 asserts Reset during that step; the following cycle must be S_RESET.
  task automatic run_instr(input logic [3:0] op, input logic iz, input int abort, input string tag);
    build_plan(op, iz);
    for (int i = 0; i < plan.size(); i++) begin
      drive(i == abort, op, iz, plan[i], $sformatf("%s op=%h step%0d", tag, op, i));
      if (i == abort) begin
        drive(1'b0, op, iz, in_state(4'd0), $sformatf("%s op=%h reset", tag, op));
        return;
      end
    end
  endtask

  initial begin
    logic [3:0] op;
    logic       iz;
    int         abort;
    bus.opcode = 4'h0;
    bus.isZero = 1'b0;

    drive(1'b1, 4'h0, 1'b0, in_state(4'd0), "reset_hold");
    drive(1'b0, 4'h0, 1'b0, in_state(4'd0), "reset_release");

    for (int o = 0; o <= 7; o++) run_instr(4'(o), 1'b0, -1, "sweep");
    run_instr(4'hA, 1'b1, -1, "beqz_taken");
    run_instr(4'hA, 1'b0, -1, "beqz_not_taken");
    run_instr(4'hB, 1'b1, -1, "jump");
    run_instr(4'hC, 1'b0, -1, "nop");
    run_instr(4'h8, 1'b0, -1, "lw");
    run_instr(4'h9, 1'b0, -1, "sw");
    run_instr(4'h8, 1'b1, 3, "lw_reset_in_mem_rd");

    for (int t = 0; t < 80; t++) begin
      op = 4'($urandom_range(0, 14));
      iz = 1'($urandom_range(0, 1));
      build_plan(op, iz);
      abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, plan.size() - 1)) : -1;
      run_instr(op, iz, abort, "rand");
    end

    run_instr(4'hF, 1'b0, 12, "halt");
    run_instr(4'h1, 1'b1, -1, "after_halt");

    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
